// File: rtl/ui_rd_arb_pkg.sv
// Shared definitions for the UI read-port arbiter: tag FIFO geometry,
// command FSM state type and a constant-width helper.
package ui_rd_arb_pkg;

  localparam int TAG_DEPTH = 16;
  localparam int TAG_PTR_W = 4;
  localparam int TAG_CNT_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Ceiling log2, evaluated at elaboration for index widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ui_rd_port_arb_rr_arbiter.sv
// Combinational round-robin picker: the first eligible port after
// last_winner (modulo NUM_PORTS) wins. The pointer lives in the parent.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [IDX_W-1:0]     last_winner,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_any
);

  logic [IDX_W-1:0] pos;

  // Walk from the farthest candidate to the nearest so the nearest
  // eligible port is the last (and winning) assignment.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      pos = IDX_W'((int'(last_winner) + i) % NUM_PORTS);
      if (eligible[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ui_rd_port_arb.sv
// Multi-port read scheduler: round-robin command issue with outstanding and
// buffer throttling, in-order owner tags, and read-data steering per port.
module ui_rd_port_arb
  import ui_rd_arb_pkg::*;
#(
  parameter int TCQ            = 100,
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 256,
  parameter int MAX_OUT        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  output logic [NUM_PORTS-1:0]            port_gnt,
  output logic                            rd_cmd_en,
  output logic [ADDR_WIDTH-1:0]           rd_cmd_addr,
  input  logic                            rd_cmd_rdy,
  input  logic                            rd_buf_full,
  input  logic                            app_rd_data_valid,
  input  logic                            app_rd_data_end,
  input  logic [APP_DATA_WIDTH-1:0]       app_rd_data,
  output logic [NUM_PORTS-1:0]            port_rd_valid,
  output logic                            port_rd_end,
  output logic [APP_DATA_WIDTH-1:0]       port_rd_data,
  output logic                            tag_err,
  output arb_state_e                      dbg_state
);

  localparam int IDX_W = clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || MAX_OUT < 1 || MAX_OUT > 15 || TCQ < 0) begin : g_bad_params
    $error("ui_rd_port_arb: parameter out of range");
  end

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          win_q, win_d;
  logic [IDX_W-1:0]          last_q, last_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [IDX_W-1:0]          tag_mem_q [TAG_DEPTH];
  logic [IDX_W-1:0]          tag_mem_d [TAG_DEPTH];
  logic [TAG_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [TAG_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [TAG_CNT_W-1:0]      tag_cnt_q, tag_cnt_d;
  logic [3:0]                out_cnt_q [NUM_PORTS];
  logic [3:0]                out_cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]      port_rd_valid_q, port_rd_valid_d;
  logic                      port_rd_end_q, port_rd_end_d;
  logic [APP_DATA_WIDTH-1:0] port_rd_data_q, port_rd_data_d;
  logic                      tag_err_q, tag_err_d;

  logic [NUM_PORTS-1:0]      eligible;
  logic [NUM_PORTS-1:0]      arb_gnt;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_any;
  logic                      tag_full;
  logic                      tag_empty;
  logic                      launch_ok;
  logic                      accept;
  logic                      beat_ok;
  logic                      pop;
  logic [IDX_W-1:0]          head;

  // Handshake: rd_cmd_en is valid, rd_cmd_rdy is ready; a command transfers
  // in any cycle where both are high, and the address is held until then.
  assign tag_full  = (tag_cnt_q == TAG_CNT_W'(TAG_DEPTH));
  assign tag_empty = (tag_cnt_q == '0);
  assign launch_ok = !rd_buf_full && !tag_full;
  assign accept    = (state_q == ISSUE) && rd_cmd_rdy && !rst;
  assign head      = tag_mem_q[rd_ptr_q];
  // A push lands only next cycle, so a beat next to the first push sees empty.
  assign beat_ok   = app_rd_data_valid && !tag_empty;
  assign pop       = beat_ok && app_rd_data_end;

  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = port_req[p] && (out_cnt_q[p] < 4'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .eligible    (eligible),
    .last_winner (last_q),
    .gnt         (arb_gnt),
    .gnt_idx     (arb_idx),
    .gnt_any     (arb_any)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (arb_any && launch_ok) begin
          state_d = ISSUE;
          win_d   = arb_idx;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (arb_gnt[p]) addr_d = port_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          state_d = IDLE;
          last_d  = win_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    port_gnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_gnt[p] = accept && (win_q == IDX_W'(p));
    end
  end

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_cnt_d = tag_cnt_q;
    if (accept) begin
      tag_mem_d[wr_ptr_q] = win_q;
      wr_ptr_d            = wr_ptr_q + TAG_PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + TAG_PTR_W'(1);
    case ({accept, pop})
      2'b10:   tag_cnt_d = tag_cnt_q + TAG_CNT_W'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - TAG_CNT_W'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_cnt_d[p] = out_cnt_q[p];
      if (accept && (win_q == IDX_W'(p))) out_cnt_d[p] = out_cnt_d[p] + 4'd1;
      if (pop && (head == IDX_W'(p)) && (out_cnt_q[p] != 4'd0)) out_cnt_d[p] = out_cnt_d[p] - 4'd1;
    end
  end

  always_comb begin
    port_rd_valid_d       = '0;
    if (beat_ok) port_rd_valid_d[head] = 1'b1;
    port_rd_end_d         = app_rd_data_end;
    port_rd_data_d        = app_rd_data;
    tag_err_d             = tag_err_q || (app_rd_data_valid && tag_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      win_q           <= '0;
      last_q          <= IDX_W'(NUM_PORTS - 1);
      addr_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      tag_cnt_q       <= '0;
      port_rd_valid_q <= '0;
      port_rd_end_q   <= 1'b0;
      port_rd_data_q  <= '0;
      tag_err_q       <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      for (int p = 0; p < NUM_PORTS; p++) out_cnt_q[p] <= '0;
    end else begin
      state_q         <= state_d;
      win_q           <= win_d;
      last_q          <= last_d;
      addr_q          <= addr_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      tag_cnt_q       <= tag_cnt_d;
      port_rd_valid_q <= port_rd_valid_d;
      port_rd_end_q   <= port_rd_end_d;
      port_rd_data_q  <= port_rd_data_d;
      tag_err_q       <= tag_err_d;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= tag_mem_d[i];
      for (int p = 0; p < NUM_PORTS; p++) out_cnt_q[p] <= out_cnt_d[p];
    end
  end

  assign rd_cmd_en     = (state_q == ISSUE);
  assign rd_cmd_addr   = addr_q;
  assign port_rd_valid = port_rd_valid_q;
  assign port_rd_end   = port_rd_end_q;
  assign port_rd_data  = port_rd_data_q;
  assign tag_err       = tag_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ui_rd_port_arb.sv
// Bench for ui_rd_port_arb: directed scenarios plus random traffic, all
// checked against a transaction-level model of commands, tags and beats.
module tb_ui_rd_port_arb;
  import ui_rd_arb_pkg::*;

  localparam int NP = 4;
  localparam int AW = 28;
  localparam int DW = 256;
  localparam int MO = 8;
  localparam int OW = 1 + AW + NP + NP + 1 + 1 + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    port_req = '0;
  logic [AW-1:0]    addr_in [NP];
  logic [NP*AW-1:0] port_addr;
  logic [NP-1:0]    port_gnt;
  logic             rd_cmd_en;
  logic [AW-1:0]    rd_cmd_addr;
  logic             rd_cmd_rdy = 1'b0;
  logic             rd_buf_full = 1'b0;
  logic             app_rd_data_valid = 1'b0;
  logic             app_rd_data_end = 1'b0;
  logic [DW-1:0]    app_rd_data = '0;
  logic [NP-1:0]    port_rd_valid;
  logic             port_rd_end;
  logic [DW-1:0]    port_rd_data;
  logic             tag_err;
  arb_state_e       dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model: pending command, owner queue, per-port outstanding.
  int            m_pend = -1;
  logic [AW-1:0] m_paddr = '0;
  int            m_last = NP - 1;
  int            m_out [NP];
  int            q [$];
  logic          m_err = 1'b0;
  logic [NP-1:0] m_rv = '0;
  logic          m_re = 1'b0;
  logic [DW-1:0] m_rd = '0;

  logic [NP-1:0] exp_gnt;
  logic [OW-1:0] exp_vec;
  logic [OW-1:0] obs_vec;

  always #5 clk = ~clk;

  assign port_addr = {addr_in[3], addr_in[2], addr_in[1], addr_in[0]};

  ui_rd_port_arb #(
    .TCQ            (100),
    .NUM_PORTS      (NP),
    .ADDR_WIDTH     (AW),
    .APP_DATA_WIDTH (DW),
    .MAX_OUT        (MO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .port_req          (port_req),
    .port_addr         (port_addr),
    .port_gnt          (port_gnt),
    .rd_cmd_en         (rd_cmd_en),
    .rd_cmd_addr       (rd_cmd_addr),
    .rd_cmd_rdy        (rd_cmd_rdy),
    .rd_buf_full       (rd_buf_full),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end   (app_rd_data_end),
    .app_rd_data       (app_rd_data),
    .port_rd_valid     (port_rd_valid),
    .port_rd_end       (port_rd_end),
    .port_rd_data      (port_rd_data),
    .tag_err           (tag_err),
    .dbg_state         (dbg_state)
  );

  always_comb begin
    exp_gnt = '0;
    if (m_pend >= 0 && rd_cmd_rdy && !rst) exp_gnt = NP'(1) << m_pend;
    exp_vec = {(m_pend >= 0), (m_pend >= 0) ? m_paddr : AW'(0), exp_gnt, m_rv,
               m_re & (|m_rv), m_err, (m_pend >= 0)};
    obs_vec = {rd_cmd_en, rd_cmd_en ? rd_cmd_addr : AW'(0), port_gnt, port_rd_valid,
               port_rd_end & (|port_rd_valid), tag_err, (dbg_state == ISSUE)};
  end

  task automatic model_step;
    int launch;
    int pp;
    if (rst) begin
      m_pend = -1;
      m_last = NP - 1;
      for (int p = 0; p < NP; p++) m_out[p] = 0;
      q.delete();
      m_err = 1'b0;
      m_rv  = '0;
      m_re  = 1'b0;
      m_rd  = '0;
    end else begin
      launch = -1;
      if (m_pend < 0 && !rd_buf_full && q.size() < 16) begin
        for (int k = 1; k <= NP; k++) begin
          pp = (m_last + k) % NP;
          if (launch < 0 && port_req[2'(pp)] && m_out[2'(pp)] < MO) launch = pp;
        end
      end
      m_rv = '0;
      m_re = app_rd_data_end;
      m_rd = app_rd_data;
      if (app_rd_data_valid) begin
        if (q.size() == 0) m_err = 1'b1;
        else begin
          m_rv = NP'(1) << q[0];
          if (app_rd_data_end) begin
            if (m_out[2'(q[0])] > 0) m_out[2'(q[0])] = m_out[2'(q[0])] - 1;
            void'(q.pop_front());
          end
        end
      end
      if (m_pend >= 0 && rd_cmd_rdy) begin
        q.push_back(m_pend);
        m_out[2'(m_pend)] = m_out[2'(m_pend)] + 1;
        m_last = m_pend;
        m_pend = -1;
      end else if (launch >= 0) begin
        m_pend  = launch;
        m_paddr = addr_in[2'(launch)];
      end
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) m_out[p] = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_defaults;
    port_req          = '0;
    rd_cmd_rdy        = 1'b1;
    rd_buf_full       = 1'b0;
    app_rd_data_valid = 1'b0;
    app_rd_data_end   = 1'b0;
    app_rd_data       = '0;
    for (int p = 0; p < NP; p++) addr_in[p] = AW'($urandom());
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    drive_defaults();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    drive_defaults();
    rst = 1'b1;
    port_req = '1;
    repeat (2) @(negedge clk);
    #2;
    total++;
    if ({rd_cmd_en, port_gnt, port_rd_valid, port_rd_end, tag_err} !== '0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=0", {rd_cmd_en, port_gnt, port_rd_valid, port_rd_end, tag_err});
    end
    total++;
    if (rd_cmd_addr !== '0) begin
      bad++;
      $display("FAIL reset_addr got=%h exp=0", rd_cmd_addr);
    end
    total++;
    if (port_rd_data !== '0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_data got=%h st=%0d exp=0", port_rd_data, dbg_state);
    end
    rst = 1'b0;
    port_req = '0;
  endtask

  task automatic test_single_port;
    logic [DW-1:0] d1, d2;
    bit granted;
    do_reset();
    d1 = rand_data();
    d2 = rand_data();
    granted = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      addr_in[0]        = AW'('h100);
      port_req          = granted ? 4'b0000 : 4'b0001;
      rd_cmd_rdy        = 1'b1;
      app_rd_data_valid = (i == 5) || (i == 6);
      app_rd_data_end   = (i == 6);
      app_rd_data       = (i == 5) ? d1 : d2;
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL single_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (port_gnt[0]) granted = 1;
      if (i == 0) begin
        total++;
        if (rd_cmd_en !== 1'b0) begin
          bad++;
          $display("FAIL single_en_early got=%b exp=0", rd_cmd_en);
        end
      end
      if (i == 1) begin
        total++;
        if ({rd_cmd_en, rd_cmd_addr, port_gnt} !== {1'b1, AW'('h100), 4'b0001}) begin
          bad++;
          $display("FAIL single_cmd got=%b/%h/%b exp=1/100/0001", rd_cmd_en, rd_cmd_addr, port_gnt);
        end
      end
      if (i == 6 || i == 7) begin
        total++;
        if ({port_rd_valid, port_rd_end, port_rd_data} !== {4'b0001, (i == 7), (i == 6) ? d1 : d2}) begin
          bad++;
          $display("FAIL single_beat cyc=%0d got=%b/%b/%h", i, port_rd_valid, port_rd_end, port_rd_data);
        end
      end
    end
  endtask

  task automatic test_round_robin;
    int ngr;
    int idx;
    do_reset();
    ngr = 0;
    for (int i = 0; i < 30 && ngr < 12; i++) begin
      @(negedge clk);
      port_req = 4'b1111;
      for (int p = 0; p < NP; p++) addr_in[p] = AW'($urandom());
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL rr_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (|port_gnt) begin
        idx = -1;
        for (int p = 0; p < NP; p++) if (port_gnt[p]) idx = p;
        total++;
        if (!$onehot(port_gnt) || idx != ngr % NP) begin
          bad++;
          $display("FAIL rr_order n=%0d got=%b exp_port=%0d", ngr, port_gnt, ngr % NP);
        end
        ngr++;
      end
    end
    total++;
    if (ngr != 12) begin
      bad++;
      $display("FAIL rr_count got=%0d exp=12", ngr);
    end
  endtask

  task automatic test_stall;
    int ngr;
    logic [AW-1:0] a2;
    do_reset();
    ngr = 0;
    a2 = AW'($urandom());
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      addr_in[2]  = (i == 0) ? a2 : AW'($urandom());
      port_req    = (ngr == 0) ? 4'b0100 : 4'b0000;
      rd_cmd_rdy  = (i == 6);
      rd_buf_full = (i % 2 == 1);
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL stall_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i >= 1 && i <= 5) begin
        total++;
        if ({rd_cmd_en, rd_cmd_addr, port_gnt} !== {1'b1, a2, 4'b0000}) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/0000", i, rd_cmd_en, rd_cmd_addr, port_gnt, a2);
        end
      end
      if (i == 6) begin
        total++;
        if (port_gnt !== 4'b0100) begin
          bad++;
          $display("FAIL stall_gnt got=%b exp=0100", port_gnt);
        end
      end
      if (|port_gnt) ngr++;
    end
    total++;
    if (ngr != 1) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=1", ngr);
    end
  endtask

  task automatic test_max_out;
    int g1, g23;
    bit seen;
    do_reset();
    g1 = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      port_req   = 4'b0010;
      addr_in[1] = AW'($urandom());
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL maxout_a cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (port_gnt[1]) g1++;
    end
    total++;
    if (g1 != MO || rd_cmd_en !== 1'b0) begin
      bad++;
      $display("FAIL maxout_limit got=%0d en=%b exp=%0d en=0", g1, rd_cmd_en, MO);
    end
    g1 = 0;
    g23 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      port_req = 4'b1110;
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL maxout_b cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (port_gnt[1]) g1++;
      if (port_gnt[2] || port_gnt[3]) g23++;
    end
    total++;
    if (g1 != 0 || g23 != 6) begin
      bad++;
      $display("FAIL maxout_skip got=%0d/%0d exp=0/6", g1, g23);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      port_req          = 4'b1110;
      app_rd_data_valid = (i == 0);
      app_rd_data_end   = (i == 0);
      app_rd_data       = rand_data();
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL maxout_c cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (port_gnt[1]) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL maxout_regrant got=0 exp=1");
    end
  endtask

  task automatic test_tag_full;
    int ngr, late_en;
    bit full_seen, seen;
    do_reset();
    ngr = 0;
    late_en = 0;
    full_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      port_req = 4'b1111;
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL full_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (full_seen && rd_cmd_en) late_en++;
      if (|port_gnt) ngr++;
      if (ngr == 16) full_seen = 1;
    end
    total++;
    if (ngr != 16 || late_en != 0) begin
      bad++;
      $display("FAIL full_block got=%0d/%0d exp=16/0", ngr, late_en);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      port_req          = 4'b1111;
      app_rd_data_valid = (i == 0);
      app_rd_data_end   = (i == 0);
      app_rd_data       = rand_data();
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL full_drain cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (|port_gnt) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL full_resume got=0 exp=1");
    end
  endtask

  task automatic test_errors;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      app_rd_data_valid = (i == 0);
      app_rd_data_end   = (i == 0);
      app_rd_data       = rand_data();
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL err_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i >= 1) begin
        total++;
        if ({port_rd_valid, tag_err} !== {4'b0000, 1'b1}) begin
          bad++;
          $display("FAIL err_sticky cyc=%0d got=%b/%b exp=0000/1", i, port_rd_valid, tag_err);
        end
      end
    end
    do_reset();
    #2;
    total++;
    if (tag_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b exp=0", tag_err);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      port_req          = (i <= 1) ? 4'b0001 : 4'b0000;
      rd_cmd_rdy        = 1'b1;
      app_rd_data_valid = (i == 1);
      app_rd_data_end   = (i == 1);
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL err_push_pop_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i == 2) begin
        total++;
        if ({port_rd_valid, tag_err} !== {4'b0000, 1'b1}) begin
          bad++;
          $display("FAIL err_push_pop got=%b/%b exp=0000/1", port_rd_valid, tag_err);
        end
      end
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      port_req   = (i < 2) ? 4'b0001 : 4'b0000;
      rd_cmd_rdy = (i == 2);
      rst        = (i == 2);
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL rst_issue_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i >= 1 && i <= 3) begin
        total++;
        if ({rd_cmd_en, port_gnt} !== {(i != 3), 4'b0000}) begin
          bad++;
          $display("FAIL rst_issue cyc=%0d got=%b/%b exp=%b/0000", i, rd_cmd_en, port_gnt, (i != 3));
        end
      end
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      port_req          = NP'($urandom_range(0, 15));
      rd_cmd_rdy        = ($urandom_range(0, 3) != 0);
      rd_buf_full       = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < NP; p++) addr_in[p] = AW'($urandom());
      app_rd_data_valid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      app_rd_data_end   = ($urandom_range(0, 1) == 1);
      app_rd_data       = rand_data();
      #2;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (|m_rv) begin
        total++;
        if (port_rd_data !== m_rd) begin
          bad++;
          $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, port_rd_data, m_rd);
        end
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_defaults();
    test_reset();
    test_single_port();
    test_round_robin();
    test_stall();
    test_max_out();
    test_tag_full();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
